spi_master_ctrl: RTL
====================

# spi_master_ctrl

Single-clock SPI master that drives the `SS_n`/`MOSI` side of the team's SPI slave + RAM wrapper and captures `MISO` read data. It serialises one 10-bit command word (2-bit opcode + `ADDR_SIZE`-bit payload) per frame. For read-data frames it then holds `SS_n` low and shifts in the returned byte. It sits between the host/test-sequencer logic and the wrapper's serial pins, all on the wrapper's clock.

## Interface
Parameters:
- `MEM_DEPTH`, 256, RAM depth; sets `ADDR_SIZE = $clog2(MEM_DEPTH)` (8 by default).
- `RD_TURN`, 2, turnaround cycles between the last command bit and the first `MISO` sample.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock; all outputs update on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: request a frame; accepted only in IDLE.
- `cmd` in 2: opcode. 00 = write address, 01 = write data, 10 = read address, 11 = read data.
- `din` in `ADDR_SIZE`: payload (address or data; don't-care for 11).
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse at end of frame.
- `rd_data` out `ADDR_SIZE`: byte captured in the last read-data frame.
- `rd_valid` out 1: one-cycle pulse with `done` on read-data frames only.
- `SS_n` out 1: slave select, active low.
- `MOSI` out 1: serial data to slave.
- `MISO` in 1: serial data from slave.

## Operation
- Reset values: `SS_n=1`, `MOSI=0`, `busy=0`, `done=0`, `rd_valid=0`, `rd_data=0`, state IDLE, counters 0. Reset applied mid-frame aborts immediately: `SS_n` is released asynchronously and no `done` is issued.
- On accept (`start=1` in IDLE), `cmd` and `din` are latched. Later changes to either are ignored. `start` while `busy` is ignored.
- Frame word: `W = {cmd, din}` (10 bits). It is shifted MSB first.
- States and low-cycle numbering (L1 = first cycle with `SS_n=0`):
  - SEL (L1): `MOSI = cmd[1]`.
  - PATH (L2): `MOSI = cmd[1]`. This is the slave's read/write path bit.
  - SHIFT (L3..L12): `MOSI = W[9]..W[0]`, one bit per cycle. A 4-bit counter counts 10 bits.
  - If `cmd != 11`, go to END after L12.
  - TURN (`RD_TURN` cycles, L13..L12+`RD_TURN`): `SS_n` stays 0, `MOSI=0`.
  - CAPTURE (8 cycles): `MISO` is sampled at the rising edge ending each cycle, MSB first, into a shift register. A bit counter counts to `ADDR_SIZE`.
  - END (1 cycle): `SS_n=1`, `MOSI=0`, `done=1`; `rd_valid=1` and `rd_data` updated if `cmd==11`. Then go to IDLE.
- `SS_n` is guaranteed high for at least one cycle between frames (END plus the IDLE cycle in which `start` is sampled). This satisfies the slave's frame-start detection.
- `rd_data` holds its value until the next read-data frame completes.

## Timing
- Accept at edge E0. L1 begins at edge E0+1; `busy=1` from E0+1 through the end of the END cycle.
- Non-read frame: 12 low cycles. END is the 13th cycle after accept. Earliest next accept is at the edge ending END+1 (14 cycles per frame).
- Read-data frame: 12 + `RD_TURN` + 8 low cycles (22 by default), then END.
- The slave asserts `rx_valid` in the cycle after L12. The master does not monitor it.
- Back-to-back `start` held high: the next frame is accepted in the first IDLE cycle after END.

## Test plan
- Reset, then `start` with `cmd=00`, `din=8'hA5` -> `SS_n` low exactly 12 cycles, and `MOSI` on L1..L12 = 0,0,0,0,1,0,1,0,0,1,0,1. Then `done` for 1 cycle with `rd_valid=0`.
- Write addr `8'h3C`, write data `8'hF0`, read addr `8'h3C`, read data (wrapper attached) -> `rd_valid` pulse with `rd_data=8'hF0`. Read frame has `SS_n` low for 22 cycles.
- `start` held high continuously with `cmd=01` -> frames separated by ≥1 `SS_n`-high cycle. `cmd`/`din` changes mid-frame do not alter `MOSI`.
- `rst_n` asserted at L7 of a write frame -> `SS_n=1` immediately, `busy=0`, no `done`. The next frame after release is correct.
- Read-data frame with `MISO` forced to the pattern 1,0,0,1,1,1,0,1 in CAPTURE -> `rd_data=8'h9D`. A following write frame leaves `rd_data=8'h9D`.
- `start` pulsed while `busy` -> ignored. Exactly one `done` per accepted frame.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   Single-clock SPI master for the SPI slave + RAM wrapper. Each frame
//   serialises one command word {cmd, din}, MSB first, after two lead-in
//   cycles that carry cmd[1]. A read-data frame (cmd = 11) then keeps SS_n
//   low through RD_TURN turnaround cycles and ADDR_SIZE capture cycles,
//   sampling MISO MSB first.
//
// Ports
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset (aborts a frame, releases SS_n)
//   start    : frame request, accepted only while idle
//   cmd      : opcode (00 wr addr, 01 wr data, 10 rd addr, 11 rd data)
//   din      : payload, latched on accept
//   busy     : frame in progress (first low cycle through END)
//   done     : one-cycle pulse in the END cycle
//   rd_data  : byte from the most recent completed read-data frame
//   rd_valid : pulses with done on read-data frames only
//   SS_n     : slave select, active low
//   MOSI     : serial data to the slave
//   MISO     : serial data from the slave
module spi_master_ctrl #(
    parameter int  MEM_DEPTH = 256,
    parameter int  RD_TURN   = 2,
    localparam int ADDR_SIZE = $clog2(MEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           cmd,
    input  logic [ADDR_SIZE-1:0] din,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int FRAME_W = ADDR_SIZE + 2;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int SUB_MAX = (RD_TURN > ADDR_SIZE) ? RD_TURN : ADDR_SIZE;
    localparam int SUB_W   = $clog2(SUB_MAX + 1);
    localparam int CAP_W   = ADDR_SIZE - 1;

    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);
    localparam logic [SUB_W-1:0] TURN_LAST = SUB_W'(RD_TURN - 1);
    localparam logic [SUB_W-1:0] CAP_LAST  = SUB_W'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_PATH,
        S_SHIFT,
        S_TURN,
        S_CAPTURE,
        S_END
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cmd_q;
    logic [FRAME_W-1:0] word_q;
    logic [BIT_W-1:0]   bit_cnt;
    logic [SUB_W-1:0]   sub_cnt;
    logic [CAP_W-1:0]   cap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Outputs are decoded from the state register only, so reset releases
    // SS_n without waiting for a clock edge.
    always_comb begin
        state_d  = state_q;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        rd_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SEL;
            end
            S_SEL: begin
                SS_n    = 1'b0;
                busy    = 1'b1;
                MOSI    = cmd_q[1];
                state_d = S_PATH;
            end
            S_PATH: begin
                SS_n    = 1'b0;
                busy    = 1'b1;
                MOSI    = cmd_q[1];
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                SS_n = 1'b0;
                busy = 1'b1;
                MOSI = word_q[FRAME_W-1];
                if (bit_cnt == BIT_LAST) begin
                    if (cmd_q != 2'b11)   state_d = S_END;
                    else if (RD_TURN > 0) state_d = S_TURN;
                    else                  state_d = S_CAPTURE;
                end
            end
            S_TURN: begin
                SS_n = 1'b0;
                busy = 1'b1;
                if (sub_cnt == TURN_LAST) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                SS_n = 1'b0;
                busy = 1'b1;
                if (sub_cnt == CAP_LAST) state_d = S_END;
            end
            S_END: begin
                busy     = 1'b1;
                done     = 1'b1;
                rd_valid = (cmd_q == 2'b11);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters wrap to zero on their last count so they are clean for the
    // next phase and for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= '0;
            word_q  <= '0;
            bit_cnt <= '0;
            sub_cnt <= '0;
            cap_q   <= '0;
            rd_data <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cmd_q   <= cmd;
                        word_q  <= {cmd, din};
                        bit_cnt <= '0;
                        sub_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    word_q  <= {word_q[FRAME_W-2:0], 1'b0};
                    bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                end
                S_TURN: begin
                    sub_cnt <= (sub_cnt == TURN_LAST) ? '0 : sub_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    // cap_q holds the bits received so far; the final MISO
                    // bit goes straight into rd_data so it is valid in END.
                    cap_q <= CAP_W'({cap_q, MISO});
                    if (sub_cnt == CAP_LAST) begin
                        rd_data <= {cap_q, MISO};
                        sub_cnt <= '0;
                    end else begin
                        sub_cnt <= sub_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
